ofifo: RTL and testbench

Output-side psum collector for the MAC array: one FIFO lane per array column, each written independently whenever that column emits a partial sum. The lanes are drained in lock-step by the downstream reader (SFU / psum writeback) only when every column holds data. It is the write-from-array, read-by-consumer counterpart of the input-side FIFO that feeds the array. It reports per-lane full/empty state as aggregate ready/valid flags and keeps a sticky overflow flag for debug.

---
 rtl/ofifo_pkg.sv | 15 +
 rtl/ofifo_if.sv | 20 ++
 rtl/ofifo_lane.sv | 57 +++++
 rtl/ofifo.sv | 56 +++++
 tb/tb_ofifo.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/ofifo_pkg.sv
// Shared constants and types for the output-side psum FIFO.
package ofifo_pkg;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;

  function automatic int ptr_w(input int d);
    return $clog2(d);
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
  } lane_flags_t;
endpackage

// File: rtl/ofifo_if.sv
// Array-write / consumer-read bundle of the output FIFO.
interface ofifo_if #(
  parameter int col = ofifo_pkg::COL,
  parameter int bw  = ofifo_pkg::BW
);
  logic [col-1:0]         wr;
  logic [col-1:0][bw-1:0] in;
  logic                   pop;
  logic [col-1:0][bw-1:0] out;
  logic                   out_valid;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_full;
  logic                   overflow;

  modport master (output wr, in, pop,
                  input  out, out_valid, o_valid, o_ready, o_full, overflow);
  modport slave  (input  wr, in, pop,
                  output out, out_valid, o_valid, o_ready, o_full, overflow);
endinterface

// File: rtl/ofifo_lane.sv
// One column's circular buffer with occupancy count and registered read port.
module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int bw    = BW,
  parameter int depth = DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [bw-1:0] wdata,
  output lane_flags_t   flags,
  output logic [bw-1:0] rdata
);
  localparam int PW = ptr_w(depth);

  logic [bw-1:0] mem [depth];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [bw-1:0] rdata_q, rdata_d;
  logic          do_wr, do_rd;

  assign flags.empty = (cnt_q == '0);
  assign flags.full  = (cnt_q == (PW+1)'(depth));
  assign rdata       = rdata_q;

  // Full/empty are judged on the start-of-cycle count, so a same-cycle pop
  // never makes room for a write into a full lane.
  always_comb begin
    do_wr    = wr_en & ~flags.full;
    do_rd    = rd_en & ~flags.empty;
    wr_ptr_d = wr_ptr_q + PW'(do_wr);
    rd_ptr_d = rd_ptr_q + PW'(do_rd);
    cnt_d    = cnt_q + (PW+1)'(do_wr) - (PW+1)'(do_rd);
    rdata_d  = do_rd ? mem[rd_ptr_q] : rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is left unreset; only pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/ofifo.sv
// Per-column psum FIFOs written independently, drained row-wise in lock-step.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col   = COL,
  parameter int bw    = BW,
  parameter int depth = DEPTH
) (
  input  logic  clk,
  input  logic  reset,
  ofifo_if.slave io
);
  lane_flags_t [col-1:0]         flags;
  logic        [col-1:0]         empty, full;
  logic        [col-1:0][bw-1:0] rdata;
  logic                          pop_acc;
  logic                          out_valid_q, out_valid_d;
  logic                          overflow_q, overflow_d;

  for (genvar g = 0; g < col; g++) begin : g_lane
    ofifo_lane #(.bw(bw), .depth(depth)) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr_en (io.wr[g]),
      .rd_en (pop_acc),
      .wdata (io.in[g]),
      .flags (flags[g]),
      .rdata (rdata[g])
    );
    assign empty[g] = flags[g].empty;
    assign full[g]  = flags[g].full;
  end

  always_comb begin
    io.o_valid  = ~|empty;
    io.o_ready  = ~|full;
    io.o_full   = &full;
    pop_acc     = io.pop & io.o_valid;
    out_valid_d = pop_acc;
    overflow_d  = overflow_q | (|(io.wr & full));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign io.out       = rdata;
  assign io.out_valid = out_valid_q;
  assign io.overflow  = overflow_q;
endmodule

// File: tb/tb_ofifo.sv
// Scoreboard bench for ofifo: per-lane model queues feed an expected-row queue.
module tb_ofifo;
  import ofifo_pkg::*;
  typedef logic [COL-1:0][BW-1:0] row_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ofifo_if #(.col(COL), .bw(BW)) io ();
  ofifo #(.col(COL), .bw(BW), .depth(DEPTH)) dut (.clk(clk), .reset(reset), .io(io));

  int nchk = 0;
  int nerr = 0;
  logic [BW-1:0] mq [COL][$];
  row_t exp_q [$];
  row_t m_out;
  logic m_ovf;

  task automatic chk(input string tag, input row_t act, input row_t exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic row_t mkrow(input int k);
    row_t r;
    for (int j = 0; j < COL; j++) r[j] = BW'((j << 8) | (k & 8'hFF));
    return r;
  endfunction

  function automatic row_t rndrow();
    row_t r;
    for (int j = 0; j < COL; j++) r[j] = BW'($urandom);
    return r;
  endfunction

  // Drive one cycle; flags checked before the edge, read port after it.
  task automatic tick(input logic [COL-1:0] w, input row_t d, input logic p);
    logic all_ne, any_full, all_full, acc;
    logic [COL-1:0] fullv;
    row_t r;
    io.wr  = w;
    io.in  = d;
    io.pop = p;
    @(negedge clk);
    all_ne = 1'b1; any_full = 1'b0; all_full = 1'b1;
    for (int i = 0; i < COL; i++) begin
      fullv[i] = (mq[i].size() == DEPTH);
      all_ne   &= (mq[i].size() != 0);
      any_full |= fullv[i];
      all_full &= fullv[i];
    end
    chk("o_valid", row_t'(io.o_valid), row_t'(all_ne));
    chk("o_ready", row_t'(io.o_ready), row_t'(!any_full));
    chk("o_full", row_t'(io.o_full), row_t'(all_full));
    chk("overflow", row_t'(io.overflow), row_t'(m_ovf));
    acc = p && all_ne;
    if (acc) begin
      for (int i = 0; i < COL; i++) r[i] = mq[i].pop_front();
      exp_q.push_back(r);
    end
    for (int i = 0; i < COL; i++)
      if (w[i]) begin
        if (fullv[i]) m_ovf = 1'b1;
        else mq[i].push_back(d[i]);
      end
    @(posedge clk);
    #1;
    chk("out_valid", row_t'(io.out_valid), row_t'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      chk("out", io.out, r);
      m_out = r;
    end else begin
      chk("out_hold", io.out, m_out);
    end
  endtask

  // Called just after a rising edge; reset asserts and releases between edges.
  task automatic do_reset();
    io.wr  = '0;
    io.pop = 1'b0;
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < COL; i++) mq[i].delete();
    exp_q.delete();
    m_out = '0;
    m_ovf = 1'b0;
    chk("rst_out", io.out, '0);
    chk("rst_out_valid", row_t'(io.out_valid), '0);
    chk("rst_o_valid", row_t'(io.o_valid), '0);
    chk("rst_o_ready", row_t'(io.o_ready), row_t'(1));
    chk("rst_o_full", row_t'(io.o_full), '0);
    chk("rst_overflow", row_t'(io.overflow), '0);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    row_t d;
    io.wr = '0; io.in = '0; io.pop = 1'b0;
    m_out = '0; m_ovf = 1'b0;
    #1 reset = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Idle pops on an empty FIFO
    repeat (3) tick('0, '0, 1'b1);

    // Skewed columns
    for (int i = 0; i < COL; i++) begin
      for (int j = 0; j < COL; j++) d[j] = BW'(16'h1000 + i);
      tick(COL'(1) << i, d, 1'b0);
    end
    tick('0, '0, 1'b1);
    tick('0, '0, 1'b0);

    // Fill, overflow, drain, second pass
    do_reset();
    for (int k = 0; k < DEPTH; k++) tick('1, mkrow(k), 1'b0);
    tick('1, mkrow(DEPTH), 1'b0);
    for (int k = 0; k < DEPTH; k++) tick('0, '0, 1'b1);
    for (int k = 0; k < 40; k++) tick('1, mkrow(100 + k), 1'b0);
    for (int k = 0; k < 41; k++) tick('0, '0, 1'b1);

    // Concurrent write + pop at count 5
    do_reset();
    for (int k = 0; k < 5; k++) tick('1, mkrow(k), 1'b0);
    for (int k = 5; k < 8; k++) tick('1, mkrow(k), 1'b1);
    for (int k = 0; k < 6; k++) tick('0, '0, 1'b1);

    // Lane 3 full: write + pop drops lane 3's write
    do_reset();
    tick('1, mkrow(0), 1'b0);
    for (int k = 1; k < DEPTH; k++) tick(COL'(8), mkrow(k), 1'b0);
    tick('1, mkrow(200), 1'b1);
    repeat (3) tick('0, '0, 1'b1);

    // Back-to-back pops
    do_reset();
    for (int k = 0; k < 10; k++) tick('1, mkrow(50 + k), 1'b0);
    for (int k = 0; k < 10; k++) tick('0, '0, 1'b1);
    tick('0, '0, 1'b1);

    // Async reset mid-stream
    for (int k = 0; k < 3; k++) tick('1, mkrow(k), 1'b0);
    tick('1, mkrow(3), 1'b1);
    do_reset();
    tick('1, mkrow(77), 1'b0);
    tick('0, '0, 1'b1);
    tick('0, '0, 1'b0);

    // Random traffic, uneven lanes, pointer wrap
    do_reset();
    for (int k = 0; k < 400; k++)
      tick(COL'($urandom), rndrow(), 1'($urandom_range(0, 2) == 0));
    for (int k = 0; k < 300; k++)
      tick(COL'($urandom | $urandom), rndrow(), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
